// File: rtl/memory_reader.sv
// Captures four parallel words on start and streams len+1 of them out over a
// valid/ready handshake, followed by a one-cycle done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; words retained from the last capture
// SEND  | offering mem_q[out_idx] until the handshake on index len_q
// DONE  | one-cycle done pulse, then back to IDLE unconditionally
module memory_reader #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       len,
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [WIDTH-1:0] In3,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [1:0]       out_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_q [4];
  logic [1:0]       len_q;
  logic             hs;
  logic [1:0]       nxt_idx;

  assign hs      = out_valid & out_ready;
  assign nxt_idx = out_idx + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      len_q     <= 2'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mem_q[0]  <= In0;
            mem_q[1]  <= In1;
            mem_q[2]  <= In2;
            mem_q[3]  <= In3;
            len_q     <= len;
            out_data  <= In0;
            out_valid <= 1'b1;
            out_last  <= (len == 2'd0);
            out_idx   <= 2'd0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Without a handshake every output simply holds.
          if (hs) begin
            if (out_idx == len_q) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_idx  <= nxt_idx;
              out_data <= mem_q[nxt_idx];
              out_last <= (nxt_idx == len_q);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: a WIDTH=10 instance for the main bursts
// and a WIDTH=5 instance for the narrow-word case, sharing clock and reset.
module tb_memory_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, out_ready, out_valid, out_last, busy, done;
  logic [1:0] len, out_idx;
  logic [9:0] in0, in1, in2, in3, out_data;

  logic       start5, ready5, valid5, last5, busy5, done5;
  logic [1:0] len5, idx5;
  logic [4:0] a0, a1, a2, a3, data5;

  int errors = 0;
  int checks = 0;

  memory_reader #(.WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .In0(in0), .In1(in1), .In2(in2), .In3(in3),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx), .busy(busy), .done(done)
  );

  memory_reader #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .len(len5),
    .In0(a0), .In1(a1), .In2(a2), .In3(a3),
    .out_data(data5), .out_valid(valid5), .out_ready(ready5),
    .out_last(last5), .out_idx(idx5), .busy(busy5), .done(done5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [9:0] d, input logic [1:0] i,
                          input logic l);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".idx"}, out_idx, i);
    chk({tag, ".last"}, out_last, l);
    chk({tag, ".busy"}, busy, 1);
  endtask

  logic [9:0] w [4];
  logic [6:0] rdy_seq;
  int k;

  initial begin
    w[0] = 10'h001; w[1] = 10'h0AA; w[2] = 10'h155; w[3] = 10'h3FF;
    rst = 1'b1; start = 0; len = 0; out_ready = 0;
    in0 = 0; in1 = 0; in2 = 0; in3 = 0;
    start5 = 0; len5 = 0; ready5 = 0; a0 = 0; a1 = 0; a2 = 0; a3 = 0;
    #2;
    chk("rst.valid", out_valid, 0);
    chk("rst.data", out_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Full burst, always ready; inputs scrambled after capture.
    in0 = w[0]; in1 = w[1]; in2 = w[2]; in3 = w[3]; len = 2'd3; start = 1;
    step();
    start = 0; out_ready = 1;
    in0 = 10'h3C3; in1 = 10'h3C3; in2 = 10'h3C3; in3 = 10'h3C3; len = 2'd0;
    chk_word("b1w0", 10'h001, 2'd0, 0);
    step(); chk_word("b1w1", 10'h0AA, 2'd1, 0);
    step(); chk_word("b1w2", 10'h155, 2'd2, 0);
    step(); chk_word("b1w3", 10'h3FF, 2'd3, 1);
    step();
    chk("b1.valid_off", out_valid, 0);
    chk("b1.done", done, 1);
    chk("b1.busy_off", busy, 0);
    step();
    chk("b1.done_once", done, 0);

    // Back-pressure pattern 1,0,0,1,1,0,1.
    in0 = w[0]; in1 = w[1]; in2 = w[2]; in3 = w[3]; len = 2'd3; start = 1;
    step();
    start = 0;
    rdy_seq = 7'b1011001;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_seq[i];
      chk_word($sformatf("bp%0d", i), w[k], k[1:0], k == 3);
      step();
      if (rdy_seq[i]) k++;
    end
    chk("bp.count", k, 4);
    chk("bp.valid_off", out_valid, 0);
    chk("bp.done", done, 1);
    step();

    // Single-word burst.
    in0 = 10'h2C5; len = 2'd0; start = 1; out_ready = 1;
    step();
    start = 0;
    chk_word("one", 10'h2C5, 2'd0, 1);
    step();
    chk("one.done", done, 1);
    chk("one.valid_off", out_valid, 0);
    step();
    chk("one.busy", busy, 0);
    chk("one.done_off", done, 0);

    // start during SEND and DONE is ignored.
    in0 = w[0]; in1 = w[1]; len = 2'd1; start = 1; out_ready = 0;
    step();
    in0 = 10'h111; start = 1;
    step();
    chk_word("ign.hold", 10'h001, 2'd0, 0);
    start = 0; out_ready = 1;
    step();
    chk_word("ign.w1", 10'h0AA, 2'd1, 1);
    step();
    chk("ign.done", done, 1);
    start = 1;
    step();
    start = 0;
    chk("ign.idle_valid", out_valid, 0);
    chk("ign.idle_busy", busy, 0);
    len = 2'd0; start = 1;
    step();
    start = 0;
    chk_word("ign.new", 10'h111, 2'd0, 1);
    step();
    chk("ign.new_done", done, 1);
    step();

    // Asynchronous reset mid-burst.
    in0 = w[0]; in1 = w[1]; in2 = w[2]; in3 = w[3]; len = 2'd3; start = 1; out_ready = 1;
    step();
    start = 0;
    step(); step();
    chk_word("ar.pre", 10'h155, 2'd2, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar.valid", out_valid, 0);
    chk("ar.data", out_data, 0);
    chk("ar.idx", out_idx, 0);
    chk("ar.busy", busy, 0);
    step();
    chk("ar.done_in_rst", done, 0);
    rst = 1'b0;
    step();
    chk("ar.done_after", done, 0);
    chk("ar.valid_after", out_valid, 0);
    len = 2'd1; start = 1;
    step();
    start = 0;
    chk_word("ar.w0", 10'h001, 2'd0, 0);
    step();
    chk_word("ar.w1", 10'h0AA, 2'd1, 1);
    step();
    chk("ar.done", done, 1);
    step();

    // Narrow instance, len=2; 5'h0A must never be offered.
    a0 = 5'h1F; a1 = 5'h00; a2 = 5'h15; a3 = 5'h0A; len5 = 2'd2; start5 = 1; ready5 = 1;
    step();
    start5 = 0;
    chk("n.w0", {valid5, last5, idx5, data5}, {1'b1, 1'b0, 2'd0, 5'h1F});
    step();
    chk("n.w1", {valid5, last5, idx5, data5}, {1'b1, 1'b0, 2'd1, 5'h00});
    step();
    chk("n.w2", {valid5, last5, idx5, data5}, {1'b1, 1'b1, 2'd2, 5'h15});
    step();
    chk("n.done", {valid5, done5, busy5}, {1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      chk("n.no_0a", valid5 && data5 == 5'h0A, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
